// File: rtl/fltflt_pkg.sv
// Shared types and constants for the binary16 golden-reference adder.
// Optional FLTFLT_SUB_EN build (see fltflt_adder) uses lzc_sig for renormalisation.
package fltflt_pkg;

    localparam int EXP_W   = 5;
    localparam int FRAC_W  = 10;
    localparam int SIG_W   = 11;
    localparam int EXP_MAX = 31;

    // Byte offsets from OP_ADDR; every 16-bit value is stored MSB first.
    localparam int OFF_F1_MSB  = 0;
    localparam int OFF_F1_LSB  = 1;
    localparam int OFF_F2_MSB  = 2;
    localparam int OFF_F2_LSB  = 3;
    localparam int OFF_RES_MSB = 4;
    localparam int OFF_RES_LSB = 5;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_RD2,
        S_RD3,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_WR0,
        S_WR1,
        S_DONE
    } state_t;

    // Leading-zero count of an 11-bit significand (returns SIG_W when zero).
    function automatic logic [3:0] lzc_sig(input logic [SIG_W-1:0] v);
        logic [3:0] n;
        logic       found;
        n     = 4'(SIG_W);
        found = 1'b0;
        for (int i = SIG_W - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 4'(SIG_W - 1 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/fltflt_if.sv
// Start/done handshake between the controlling bench and the adder engine.
interface fltflt_if;
    logic start;
    logic done;

    modport master (output start, input  done);
    modport slave  (input  start, output done);
endinterface

// File: rtl/fltflt_mem.sv
// Byte-wide data memory: synchronous write, asynchronous read, no reset.
module fltflt_mem #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem_core [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_core[waddr] <= wdata;
        end
    end

    assign rdata = mem_core[raddr];

endmodule

// File: rtl/fltflt_adder.sv
// Binary16 truncating adder reading/writing its operands in an embedded memory.
// Define FLTFLT_SUB_EN to subtract magnitudes when signs differ.
module fltflt_adder
    import fltflt_pkg::*;
#(
    parameter int OP_ADDR   = 128,
    parameter int MEM_DEPTH = 256
) (
    input  logic     clk,
    input  logic     reset,
    fltflt_if.slave  ctl
);

    localparam int AW = $clog2(MEM_DEPTH);

    function automatic logic [AW-1:0] addr_of(input int off);
        return AW'(OP_ADDR + off);
    endfunction

    state_t             state_q, state_d;
    logic [15:0]        op1_q, op1_d;
    logic [15:0]        op2_q, op2_d;
    logic [SIG_W-1:0]   big_sig_q, big_sig_d;
    logic [SIG_W-1:0]   small_sig_q, small_sig_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic               sign_q, sign_d;
    logic               sub_q, sub_d;
    logic [SIG_W:0]     sum_q, sum_d;
    logic [15:0]        res_q, res_d;

    logic               mem_we;
    logic [AW-1:0]      mem_waddr;
    logic [7:0]         mem_wdata;
    logic [AW-1:0]      mem_raddr;
    logic [7:0]         mem_rdata;

    fltflt_mem #(.DEPTH(MEM_DEPTH), .AW(AW)) data_mem1 (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    // Alignment: order by magnitude, flt1 winning ties, so the same ordering serves both builds.
    logic [EXP_W-1:0] e1, e2, exp_diff;
    logic [SIG_W-1:0] s1, s2, big_sig, small_raw, small_al;
    logic             f1_big, eff_sub, res_sign;

    assign e1        = op1_q[14:10];
    assign e2        = op2_q[14:10];
    assign s1        = {|e1, op1_q[FRAC_W-1:0]};
    assign s2        = {|e2, op2_q[FRAC_W-1:0]};
    assign f1_big    = op1_q[14:0] >= op2_q[14:0];
    assign exp_diff  = f1_big ? (e1 - e2) : (e2 - e1);
    assign big_sig   = f1_big ? s1 : s2;
    assign small_raw = f1_big ? s2 : s1;
    assign small_al  = (exp_diff >= EXP_W'(SIG_W)) ? '0 : (small_raw >> exp_diff);

`ifdef FLTFLT_SUB_EN
    assign eff_sub  = op1_q[15] ^ op2_q[15];
    assign res_sign = f1_big ? op1_q[15] : op2_q[15];
`else
    assign eff_sub  = 1'b0;
    assign res_sign = op1_q[15];
`endif

    logic [EXP_W:0]    norm_exp;
    logic [FRAC_W-1:0] norm_frac;
    logic [15:0]       norm_res;
    logic              norm_zero;
    logic [3:0]        lz;

    always_comb begin
        lz        = '0;
        norm_zero = (sum_q == '0);
        norm_exp  = {1'b0, exp_q};
        norm_frac = sum_q[FRAC_W-1:0];
        if (sum_q[SIG_W]) begin
            norm_frac = sum_q[SIG_W-1:1];
            norm_exp  = norm_exp + 1'b1;
        end
`ifdef FLTFLT_SUB_EN
        if (sub_q) begin
            // Left-normalise, but never drive the exponent field below zero.
            lz = lzc_sig(sum_q[SIG_W-1:0]);
            if ({2'b00, lz} < norm_exp) begin
                norm_frac = sum_q[FRAC_W-1:0] << lz;
                norm_exp  = norm_exp - (EXP_W+1)'(lz);
            end else begin
                norm_frac = sum_q[FRAC_W-1:0] << norm_exp;
                norm_exp  = '0;
            end
        end
        if (norm_zero && sub_q) begin
            norm_res = 16'h0000;
        end else
`endif
        if (norm_zero) begin
            norm_res = {sign_q, 15'b0};
        end else if (norm_exp >= (EXP_W+1)'(EXP_MAX)) begin
            norm_res = {sign_q, 5'(EXP_MAX), 10'b0};
        end else begin
            norm_res = {sign_q, norm_exp[EXP_W-1:0], norm_frac};
        end
    end

    always_comb begin
        state_d     = state_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        big_sig_d   = big_sig_q;
        small_sig_d = small_sig_q;
        exp_d       = exp_q;
        sign_d      = sign_q;
        sub_d       = sub_q;
        sum_d       = sum_q;
        res_d       = res_q;
        mem_we      = 1'b0;
        mem_waddr   = addr_of(OFF_RES_MSB);
        mem_wdata   = 8'h00;
        mem_raddr   = addr_of(OFF_F1_MSB);

        case (state_q)
            S_IDLE: if (!ctl.start) state_d = S_RD0;
            S_RD0: begin
                mem_raddr   = addr_of(OFF_F1_MSB);
                op1_d[15:8] = mem_rdata;
                state_d     = S_RD1;
            end
            S_RD1: begin
                mem_raddr   = addr_of(OFF_F1_LSB);
                op1_d[7:0]  = mem_rdata;
                state_d     = S_RD2;
            end
            S_RD2: begin
                mem_raddr   = addr_of(OFF_F2_MSB);
                op2_d[15:8] = mem_rdata;
                state_d     = S_RD3;
            end
            S_RD3: begin
                mem_raddr   = addr_of(OFF_F2_LSB);
                op2_d[7:0]  = mem_rdata;
                state_d     = S_ALIGN;
            end
            S_ALIGN: begin
                big_sig_d   = big_sig;
                small_sig_d = small_al;
                exp_d       = f1_big ? e1 : e2;
                sign_d      = res_sign;
                sub_d       = eff_sub;
                state_d     = S_ADD;
            end
            S_ADD: begin
                sum_d   = sub_q ? ({1'b0, big_sig_q} - {1'b0, small_sig_q})
                                : ({1'b0, big_sig_q} + {1'b0, small_sig_q});
                state_d = S_NORM;
            end
            S_NORM: begin
                res_d   = norm_res;
                state_d = S_WR0;
            end
            S_WR0: begin
                mem_we    = 1'b1;
                mem_waddr = addr_of(OFF_RES_MSB);
                mem_wdata = res_q[15:8];
                state_d   = S_WR1;
            end
            S_WR1: begin
                mem_we    = 1'b1;
                mem_waddr = addr_of(OFF_RES_LSB);
                mem_wdata = res_q[7:0];
                state_d   = S_DONE;
            end
            S_DONE: if (ctl.start) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op1_q       <= '0;
            op2_q       <= '0;
            big_sig_q   <= '0;
            small_sig_q <= '0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
            sub_q       <= 1'b0;
            sum_q       <= '0;
            res_q       <= '0;
        end else begin
            state_q     <= state_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            big_sig_q   <= big_sig_d;
            small_sig_q <= small_sig_d;
            exp_q       <= exp_d;
            sign_q      <= sign_d;
            sub_q       <= sub_d;
            sum_q       <= sum_d;
            res_q       <= res_d;
        end
    end

    assign ctl.done = (state_q == S_DONE);

endmodule

// File: tb/tb_fltflt_adder.sv
// Randomised and directed bench for fltflt_adder against an integer-arithmetic model.
module tb_fltflt_adder;
    import fltflt_pkg::*;

    localparam int OP = 128;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    fltflt_if bus ();

    fltflt_adder #(.OP_ADDR(OP), .MEM_DEPTH(256)) dut (
        .clk   (clk),
        .reset (reset),
        .ctl   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic over the binary16 fields.
    function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        int ea, eb, ma, mb, e, mbig, msml, d, s, sign;
        bit a_big;
        ea = int'(a[14:10]);  eb = int'(b[14:10]);
        ma = (ea != 0 ? 1024 : 0) + int'(a[9:0]);
        mb = (eb != 0 ? 1024 : 0) + int'(b[9:0]);
        a_big = (ea > eb) || (ea == eb && ma >= mb);
        e    = a_big ? ea : eb;
        mbig = a_big ? ma : mb;
        msml = a_big ? mb : ma;
        d    = a_big ? ea - eb : eb - ea;
        msml = (d >= 11) ? 0 : msml / (1 << d);
        sign = int'(a[15]);
`ifdef FLTFLT_SUB_EN
        if (a[15] != b[15]) begin
            sign = a_big ? int'(a[15]) : int'(b[15]);
            s = mbig - msml;
            if (s == 0) return 16'h0000;
            while (s < 1024 && e > 0) begin
                s = s * 2;
                e = e - 1;
            end
            return 16'((sign << 15) | (e << 10) | (s % 1024));
        end
`endif
        s = mbig + msml;
        if (s >= 2048) begin
            s = s / 2;
            e = e + 1;
        end
        if (s == 0) return 16'(sign << 15);
        if (e >= 31) return 16'((sign << 15) | (31 << 10));
        return 16'((sign << 15) | (e << 10) | (s % 1024));
    endfunction

    task automatic load_ops(input logic [15:0] a, input logic [15:0] b, input logic [15:0] poison);
        dut.data_mem1.mem_core[OP + 0] = a[15:8];
        dut.data_mem1.mem_core[OP + 1] = a[7:0];
        dut.data_mem1.mem_core[OP + 2] = b[15:8];
        dut.data_mem1.mem_core[OP + 3] = b[7:0];
        dut.data_mem1.mem_core[OP + 4] = poison[15:8];
        dut.data_mem1.mem_core[OP + 5] = poison[7:0];
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] exp_r, got_r;
        int n;
        exp_r = ref_add(a, b);
        @(negedge clk);
        bus.start = 1'b1;
        load_ops(a, b, ~exp_r);
        repeat (2) @(negedge clk);
        check("done_while_start", 32'(bus.done), 32'd0);
        bus.start = 1'b0;
        n = 0;
        while (n < 30) begin
            @(posedge clk);
            n++;
            #1;
            if (bus.done) break;
        end
        check("latency", 32'(n), 32'd10);
        repeat (3) @(posedge clk);
        #1;
        check("done_hold", 32'(bus.done), 32'd1);
        got_r = {dut.data_mem1.mem_core[OP + 4], dut.data_mem1.mem_core[OP + 5]};
        check("result", 32'(got_r), 32'(exp_r));
        $display("op %h + %h -> %h (exp %h) lat=%0d", a, b, got_r, exp_r, n);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        check("done_clear", 32'(bus.done), 32'd0);
    endtask

    logic [15:0] dir_a [8] = '{16'h1A04, 16'h4204, 16'h4A10, 16'h4200, 16'h5604, 16'h7800, 16'h0000, 16'hC204};
    logic [15:0] dir_b [8] = '{16'h1A04, 16'h4204, 16'h4204, 16'h5604, 16'h4200, 16'h7800, 16'h4204, 16'h4204};

    initial begin
        logic [15:0] ra, rb;
        reset     = 1'b1;
        bus.start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_state", 32'(dut.state_q), 32'(S_IDLE));
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_op(dir_a[i], dir_b[i]);

        for (int i = 0; i < 40; i++) begin
            ra = {1'($urandom_range(0, 1)), 5'($urandom_range(1, 30)), 10'($urandom)};
            rb = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 30)), 10'($urandom)};
            run_op(ra, rb);
        end

        // Abort in RD2: nothing written, FSM back in IDLE with done low.
        @(negedge clk);
        load_ops(16'h4A10, 16'h4204, 16'hBEEF);
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_in_rd2", 32'(dut.state_q), 32'(S_RD2));
        @(negedge clk);
        reset     = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_state", 32'(dut.state_q), 32'(S_IDLE));
        repeat (12) @(negedge clk);
        check("abort_nowrite", 32'({dut.data_mem1.mem_core[OP + 4], dut.data_mem1.mem_core[OP + 5]}), 32'h0000BEEF);
        check("abort_idle_done", 32'(bus.done), 32'd0);

        run_op(16'h4A10, 16'h4204);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
